// File: rtl/fetch_pkg.sv
// ============================================================================
// Module  : fetch_pkg
// Brief   : Shared types and widths for the PC/IR fetch sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int JIMM_W  = 13;
  localparam int BOFF_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    NS_SEQ    = 2'b00,
    NS_JUMP   = 2'b01,
    NS_BRANCH = 2'b10,
    NS_JR     = 2'b11
  } next_sel_t;

endpackage

`default_nettype wire

// File: rtl/pc_target_calc.sv
// ============================================================================
// Module  : pc_target_calc
// Brief   : Combinational next-PC selection for the HOLD-state PC update.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_target_calc
  import fetch_pkg::*;
(
  input  logic [INSTR_W-1:0] i_pc,
  input  logic [JIMM_W-1:0]  i_ir,
  input  logic [1:0]         i_next_sel,
  input  logic               i_branch_taken,
  input  logic [INSTR_W-1:1] i_jr_target,
  output logic [INSTR_W-1:0] o_next_pc
);

  logic [INSTR_W-1:0] w_boff;

  // Byte offset: signed word offset from IR[7:0], doubled.
  assign w_boff = {{(INSTR_W-BOFF_W-1){i_ir[BOFF_W-1]}}, i_ir[BOFF_W-1:0], 1'b0};

  always_comb begin
    o_next_pc = i_pc;
    case (next_sel_t'(i_next_sel))
      NS_SEQ:    o_next_pc = i_pc;
      NS_JUMP:   o_next_pc = {i_pc[INSTR_W-1:JIMM_W+1], i_ir, 1'b0};
      NS_BRANCH: o_next_pc = i_branch_taken ? (i_pc + w_boff) : i_pc;
      NS_JR:     o_next_pc = {i_jr_target, 1'b0};
      default:   o_next_pc = i_pc;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
// ============================================================================
// Module  : pc_fetch_sequencer
// Brief   : PC/IR owner running req/ready instruction fetch; optional fetch
//           timeout with sticky FetchFault under macro FETCH_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Run,
  input  logic        MemReady,
  input  logic [15:0] MemData,
  input  logic        PCWrite,
  input  logic [1:0]  NextSel,
  input  logic        BranchTaken,
  input  logic [15:0] JRTarget,
  output logic        MemReq,
  output logic [15:0] MemAddr,
  output logic [15:0] PC,
  output logic [15:0] IR,
  output logic        IRValid
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic        FetchFault
`endif
);

  localparam logic [15:0] c_reset_pc = {RESET_PC[15:1], 1'b0};

  state_t       r_state;
  state_t       w_next_state;
  logic [15:0]  r_pc;
  logic [15:0]  r_ir;
  logic         r_irvalid;
  logic [15:0]  w_pc_target;
  logic         w_fetch_done;
  logic         w_pc_apply;
  logic         w_timeout;
  logic         w_fault;

  assign w_fetch_done = (r_state == FETCH) && MemReady;
  assign w_pc_apply   = (r_state == HOLD) && PCWrite;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [3:0] c_wait_last = 4'(TIMEOUT_CYCLES - 1);

  logic [3:0] r_wait;
  logic       r_fault;

  assign w_timeout  = (r_state == FETCH) && !MemReady && (r_wait == c_wait_last);
  assign w_fault    = r_fault;
  assign FetchFault = r_fault;

  // Counter is held at zero outside FETCH, so every FETCH entry starts fresh.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_wait  <= 4'd0;
      r_fault <= 1'b0;
    end else begin
      if (r_state != FETCH) begin
        r_wait <= 4'd0;
      end else if (!MemReady) begin
        r_wait <= r_wait + 4'd1;
      end
      if (w_timeout) begin
        r_fault <= 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_fault   = 1'b0;
`endif

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (Run && !w_fault) w_next_state = FETCH;
      FETCH: begin
        if (MemReady)       w_next_state = HOLD;
        else if (w_timeout) w_next_state = IDLE;
      end
      HOLD:    if (PCWrite) w_next_state = Run ? FETCH : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  pc_target_calc u_target (
    .i_pc           (r_pc),
    .i_ir           (r_ir[JIMM_W-1:0]),
    .i_next_sel     (NextSel),
    .i_branch_taken (BranchTaken),
    .i_jr_target    (JRTarget[15:1]),
    .o_next_pc      (w_pc_target)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_pc      <= c_reset_pc;
      r_ir      <= 16'h0000;
      r_irvalid <= 1'b0;
    end else begin
      r_irvalid <= w_fetch_done;
      if (w_fetch_done) begin
        r_ir <= MemData;
        r_pc <= r_pc + 16'd2;
      end else if (w_pc_apply) begin
        r_pc <= w_pc_target;
      end
    end
  end

  // MemReq decodes the state register, so async Reset drops it at once.
  assign MemReq  = (r_state == FETCH);
  assign MemAddr = r_pc;
  assign PC      = r_pc;
  assign IR      = r_ir;
  assign IRValid = r_irvalid;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
// ============================================================================
// Module  : tb_pc_fetch_sequencer
// Brief   : Directed self-checking bench; two instances (RESET_PC 0x0000 and
//           0xFFFE) share all inputs. Timeout scenario under FETCH_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Run = 1'b0;
  logic        MemReady = 1'b0;
  logic [15:0] MemData = 16'h0000;
  logic        PCWrite = 1'b0;
  logic [1:0]  NextSel = 2'b00;
  logic        BranchTaken = 1'b0;
  logic [15:0] JRTarget = 16'h0000;

  logic        MemReq_a, IRValid_a, MemReq_b, IRValid_b;
  logic [15:0] MemAddr_a, PC_a, IR_a, MemAddr_b, PC_b, IR_b;
`ifdef FETCH_TIMEOUT_EN
  logic        Fault_a, Fault_b;
`endif

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  pc_fetch_sequencer #(.RESET_PC(16'h0000), .TIMEOUT_CYCLES(15)) u_dut_a (
    .CLK(CLK), .Reset(Reset), .Run(Run), .MemReady(MemReady), .MemData(MemData),
    .PCWrite(PCWrite), .NextSel(NextSel), .BranchTaken(BranchTaken), .JRTarget(JRTarget),
    .MemReq(MemReq_a), .MemAddr(MemAddr_a), .PC(PC_a), .IR(IR_a), .IRValid(IRValid_a)
`ifdef FETCH_TIMEOUT_EN
    , .FetchFault(Fault_a)
`endif
  );

  pc_fetch_sequencer #(.RESET_PC(16'hFFFE), .TIMEOUT_CYCLES(15)) u_dut_b (
    .CLK(CLK), .Reset(Reset), .Run(Run), .MemReady(MemReady), .MemData(MemData),
    .PCWrite(PCWrite), .NextSel(NextSel), .BranchTaken(BranchTaken), .JRTarget(JRTarget),
    .MemReq(MemReq_b), .MemAddr(MemAddr_b), .PC(PC_b), .IR(IR_b), .IRValid(IRValid_b)
`ifdef FETCH_TIMEOUT_EN
    , .FetchFault(Fault_b)
`endif
  );

  // Stimulus helpers; all checks live in the test_* tasks.
  task automatic fetch_word(input logic [15:0] d);
    MemReady = 1'b1;
    MemData  = d;
    @(negedge CLK);
    MemReady = 1'b0;
  endtask

  task automatic pc_write(input logic [1:0] sel, input logic taken,
                          input logic [15:0] jr, input logic run);
    PCWrite = 1'b1; NextSel = sel; BranchTaken = taken; JRTarget = jr; Run = run;
    @(negedge CLK);
    PCWrite = 1'b0; BranchTaken = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Run = 1'b0; MemReady = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    checks++; if (PC_a !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", PC_a); end
    checks++; if (IR_a !== 16'h0000) begin failures++; $display("FAIL reset_ir got=%h exp=0000", IR_a); end
    checks++; if (IRValid_a !== 1'b0) begin failures++; $display("FAIL reset_irvalid got=%b exp=0", IRValid_a); end
    checks++; if (MemReq_a !== 1'b0) begin failures++; $display("FAIL reset_memreq got=%b exp=0", MemReq_a); end
    checks++; if (MemAddr_b !== 16'hFFFE) begin failures++; $display("FAIL reset_memaddr_b got=%h exp=fffe", MemAddr_b); end
    MemReady = 1'b0;
  endtask

  task automatic test_first_fetch();
    Reset = 1'b0; Run = 1'b1; MemReady = 1'b1; MemData = 16'h1234;
    @(negedge CLK);
    checks++; if (MemReq_a !== 1'b1) begin failures++; $display("FAIL ff_memreq got=%b exp=1", MemReq_a); end
    checks++; if (MemAddr_a !== 16'h0000) begin failures++; $display("FAIL ff_memaddr got=%h exp=0000", MemAddr_a); end
    @(negedge CLK);
    MemReady = 1'b0;
    checks++; if (IR_a !== 16'h1234) begin failures++; $display("FAIL ff_ir got=%h exp=1234", IR_a); end
    checks++; if (PC_a !== 16'h0002) begin failures++; $display("FAIL ff_pc got=%h exp=0002", PC_a); end
    checks++; if (IRValid_a !== 1'b1) begin failures++; $display("FAIL ff_irvalid got=%b exp=1", IRValid_a); end
    checks++; if (MemReq_a !== 1'b0) begin failures++; $display("FAIL ff_hold_memreq got=%b exp=0", MemReq_a); end
    @(negedge CLK);
    checks++; if (IRValid_a !== 1'b0) begin failures++; $display("FAIL ff_irvalid_pulse got=%b exp=0", IRValid_a); end
    checks++; if (PC_a !== 16'h0002) begin failures++; $display("FAIL ff_hold_pc got=%h exp=0002", PC_a); end
  endtask

  task automatic test_jump();
    pc_write(2'b11, 1'b0, 16'h8000, 1'b1);
    checks++; if (MemAddr_a !== 16'h8000 || MemReq_a !== 1'b1) begin
      failures++; $display("FAIL jr_to_fetch addr=%h req=%b exp=8000/1", MemAddr_a, MemReq_a); end
    fetch_word(16'h1FFF);
    pc_write(2'b01, 1'b0, 16'h0000, 1'b0);
    checks++; if (PC_a !== 16'hBFFE) begin failures++; $display("FAIL jump_pc got=%h exp=bffe", PC_a); end
    // MemReady in IDLE must not load IR.
    MemReady = 1'b1; MemData = 16'hDEAD;
    @(negedge CLK);
    MemReady = 1'b0;
    checks++; if (IR_a !== 16'h1FFF || MemReq_a !== 1'b0) begin
      failures++; $display("FAIL idle_ignore ir=%h req=%b exp=1fff/0", IR_a, MemReq_a); end
  endtask

  task automatic test_branch();
    Run = 1'b1;
    @(negedge CLK);
    fetch_word(16'h0000);
    pc_write(2'b11, 1'b0, 16'h0010, 1'b1);
    fetch_word(16'h00FE);
    checks++; if (PC_a !== 16'h0012) begin failures++; $display("FAIL br_pre_pc got=%h exp=0012", PC_a); end
    pc_write(2'b10, 1'b1, 16'h0000, 1'b0);
    checks++; if (PC_a !== 16'h000E) begin failures++; $display("FAIL br_taken_pc got=%h exp=000e", PC_a); end
    Run = 1'b1;
    @(negedge CLK);
    fetch_word(16'h0000);
    pc_write(2'b11, 1'b0, 16'h0010, 1'b1);
    fetch_word(16'h00FE);
    pc_write(2'b10, 1'b0, 16'h0000, 1'b0);
    checks++; if (PC_a !== 16'h0012) begin failures++; $display("FAIL br_not_taken_pc got=%h exp=0012", PC_a); end
  endtask

  task automatic test_wrap_jr();
    Reset = 1'b1; Run = 1'b0;
    @(negedge CLK);
    checks++; if (PC_b !== 16'hFFFE) begin failures++; $display("FAIL wrap_reset_pc got=%h exp=fffe", PC_b); end
    Reset = 1'b0; Run = 1'b1;
    @(negedge CLK);
    checks++; if (MemAddr_b !== 16'hFFFE) begin failures++; $display("FAIL wrap_memaddr got=%h exp=fffe", MemAddr_b); end
    fetch_word(16'h0000);
    pc_write(2'b00, 1'b0, 16'h0000, 1'b0);
    checks++; if (PC_b !== 16'h0000) begin failures++; $display("FAIL wrap_seq_pc got=%h exp=0000", PC_b); end
    Run = 1'b1;
    @(negedge CLK);
    fetch_word(16'h0000);
    pc_write(2'b11, 1'b0, 16'h4321, 1'b0);
    checks++; if (PC_b !== 16'h4320) begin failures++; $display("FAIL jr_pc got=%h exp=4320", PC_b); end
  endtask

  task automatic test_stall_reset();
    Run = 1'b1;
    @(negedge CLK);
    Run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      PCWrite = 1'b1; NextSel = 2'b11; JRTarget = 16'h0100;
      @(negedge CLK);
      checks++; if (MemReq_a !== 1'b1 || PC_a !== 16'h4320) begin
        failures++; $display("FAIL stall_%0d req=%b pc=%h exp=1/4320", i, MemReq_a, PC_a); end
    end
    PCWrite = 1'b0;
    #2 Reset = 1'b1;
    #1;
    checks++; if (MemReq_a !== 1'b0 || PC_a !== 16'h0000) begin
      failures++; $display("FAIL async_reset req=%b pc=%h exp=0/0000", MemReq_a, PC_a); end
    @(negedge CLK);
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    Reset = 1'b1; Run = 1'b0; MemReady = 1'b0;
    @(negedge CLK);
    Reset = 1'b0; Run = 1'b1;
    @(negedge CLK);
    n = 0;
    while (MemReq_a === 1'b1 && n < 40) begin
      n++;
      @(negedge CLK);
    end
    checks++; if (n != 15) begin failures++; $display("FAIL timeout_cycles got=%0d exp=15", n); end
    checks++; if (Fault_a !== 1'b1) begin failures++; $display("FAIL timeout_fault got=%b exp=1", Fault_a); end
    checks++; if (PC_a !== 16'h0000 || IR_a !== 16'h0000) begin
      failures++; $display("FAIL timeout_regs pc=%h ir=%h exp=0000/0000", PC_a, IR_a); end
    repeat (4) @(negedge CLK);
    checks++; if (MemReq_a !== 1'b0) begin failures++; $display("FAIL fault_blocks_run got=%b exp=0", MemReq_a); end
    Reset = 1'b1;
    @(negedge CLK);
    checks++; if (Fault_a !== 1'b0) begin failures++; $display("FAIL fault_clear got=%b exp=0", Fault_a); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_fetch();
    test_jump();
    test_branch();
    test_wrap_jr();
    test_stall_reset();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
